switch_led_controller: RTL and testbench
========================================

Name: switch_led_controller

Overview:
- Sequencing controller for the FPGA switch-to-LED datapath.
- Synchronises and debounces N board switches and one mode push-button.
- Runs a 4-mode FSM that selects how the debounced switch vector drives the LED bank: pass-through, blink, chase, or invert.
- Sits between the raw board I/O pins and the LED pins; replaces the direct combinational switch-to-LED wiring on the board top level.

Parameters:
- N, 4, number of switches and LEDs.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles (≥2) before a switch or button change is accepted.
- TICK_CYCLES, 50000, clock cycles (≥2) per pattern step in BLINK and CHASE.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset; all state clears immediately on assertion.
- i_switch  input  N  raw asynchronous switch levels.
- i_mode_btn  input  1  raw asynchronous mode button, active-high.
- o_LED  output  N  registered LED drive.
- o_mode  output  2  current mode: 0=PASS, 1=BLINK, 2=CHASE, 3=INVERT.
- o_switch_db  output  N  debounced switch vector.

Behaviour:
- Reset values: o_LED=0, o_mode=0 (PASS), o_switch_db=0, btn_db=0, debounce counters=0, tick counter=0, phase=0, onehot=1 (bit 0 set). Reset mid-operation aborts any debounce or tick in progress. Sync flops clear to 0.
- Synchronisers: each i_switch bit and i_mode_btn pass through a 2-flop synchroniser (sync).
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES):
  - sync==db: counter clears to 0.
  - sync!=db and counter<DEBOUNCE_CYCLES-1: counter increments.
  - sync!=db and counter==DEBOUNCE_CYCLES-1: db<=sync and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and db is unchanged.
- Latency: input edge → o_switch_db takes 2+DEBOUNCE_CYCLES cycles; → o_LED takes 3+DEBOUNCE_CYCLES cycles.
- Mode FSM:
  - Advances PASS→BLINK→CHASE→INVERT→PASS on each rising edge of btn_db (btn_db=1 while its previous value was 0).
  - Holding the button gives exactly one advance; release causes no transition.
- Tick generator:
  - Counts 0..TICK_CYCLES-1, then wraps to 0.
  - tick=1 for the single cycle in which count==TICK_CYCLES-1.
  - Runs in all modes.
- Mode-change cycle: tick counter←0, phase←0, onehot←1. A mode change in the same cycle as a tick takes priority, and the tick is discarded.
- On tick with no mode change: phase toggles; onehot rotates left, with bit N-1 wrapping to bit 0.
- o_LED, registered every cycle from the current state:
  - PASS: o_switch_db.
  - BLINK: phase ? o_switch_db : 0.
  - CHASE: onehot, independent of switches.
  - INVERT: ~o_switch_db.
- No other state transitions. o_mode is a direct view of the state register.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EN.
- Defined: debounce logic as specified above.
- Undefined:
  - Debounce counters are not built.
  - db<=sync every cycle, for both switches and button.
  - Switch→o_switch_db latency is 3 cycles; switch→o_LED latency is 4 cycles.
  - Mode FSM, tick generator and LED selection are unchanged.

Test Plan (N=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=8, macro defined):
- Reset → apply i_switch=4'b1010 in PASS → o_switch_db=1010 exactly 6 cycles later; o_LED=1010 exactly 7 cycles later; o_LED=0 before that.
- i_switch=4'b0100 held for 3 cycles, then restored to the previous value → o_switch_db and o_LED never change.
- Press i_mode_btn for 10 cycles, four separate times → o_mode goes 1, 2, 3, 0, one step per press; INVERT with switches 0101 gives o_LED=1010.
- CHASE mode with any switches → o_LED sequence 0001, 0010, 0100, 1000, 0001, changing every 8 cycles after mode entry.
- BLINK with switches 1001 → o_LED alternates 0000/1001 every 8 cycles, starting 0000; a button press landing on a tick cycle gives CHASE with onehot=0001 and tick restarted.
- Assert i_rst_n=0 mid-CHASE, asynchronously between clock edges → o_LED=0 and o_mode=0 immediately, without waiting for a clock edge; after release, PASS with o_switch_db=0.

Source files
------------

// File: rtl/switch_led_controller.sv
// Switch/button synchroniser + debouncer feeding a 4-mode LED pattern FSM.
// Optional macro SWITCH_DEBOUNCE_EN builds the per-bit debounce counters; without it db follows sync.
module switch_led_controller #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TICK_CYCLES     = 50000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_switch,
  input  logic         i_mode_btn,
  output logic [N-1:0] o_LED,
  output logic [1:0]   o_mode,
  output logic [N-1:0] o_switch_db
);

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    BLINK  = 2'd1,
    CHASE  = 2'd2,
    INVERT = 2'd3
  } mode_e;

  localparam int TCNT_W = $clog2(TICK_CYCLES);
  localparam logic [TCNT_W-1:0] TICK_MAX = TCNT_W'(TICK_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || TICK_CYCLES < 2) begin : g_param_check
    $error("switch_led_controller: DEBOUNCE_CYCLES and TICK_CYCLES must be >= 2");
  end

  // Bit N carries the mode button alongside the switches through sync and debounce.
  logic [N:0] sync1_q, sync2_q;
  logic [N:0] db_q, db_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= {i_mode_btn, i_switch};
      sync2_q <= sync1_q;
      db_q    <= db_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i <= N; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign db_d = sync2_q;
`endif

  mode_e             mode_q;
  logic              btn_prev_q;
  logic [TCNT_W-1:0] tick_q;
  logic              phase_q;
  logic [N-1:0]      onehot_q;
  logic [N-1:0]      led_q;
  logic              mode_adv;
  logic              tick;

  assign mode_adv = db_q[N] & ~btn_prev_q;
  assign tick     = (tick_q == TICK_MAX);

  // A mode change restarts the pattern and swallows a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= PASS;
      btn_prev_q <= 1'b0;
      tick_q     <= '0;
      phase_q    <= 1'b0;
      onehot_q   <= N'(1);
      led_q      <= '0;
    end else begin
      btn_prev_q <= db_q[N];
      if (mode_adv) begin
        case (mode_q)
          PASS:    mode_q <= BLINK;
          BLINK:   mode_q <= CHASE;
          CHASE:   mode_q <= INVERT;
          default: mode_q <= PASS;
        endcase
        tick_q   <= '0;
        phase_q  <= 1'b0;
        onehot_q <= N'(1);
      end else if (tick) begin
        tick_q   <= '0;
        phase_q  <= ~phase_q;
        onehot_q <= (onehot_q << 1) | (onehot_q >> (N - 1));
      end else begin
        tick_q <= tick_q + TCNT_W'(1);
      end

      case (mode_q)
        PASS:    led_q <= db_q[N-1:0];
        BLINK:   led_q <= phase_q ? db_q[N-1:0] : '0;
        CHASE:   led_q <= onehot_q;
        default: led_q <= ~db_q[N-1:0];
      endcase
    end
  end

  assign o_LED       = led_q;
  assign o_mode      = mode_q;
  assign o_switch_db = db_q[N-1:0];

endmodule

// File: tb/tb_switch_led_controller.sv
// Directed self-checking bench for switch_led_controller (N=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=8).
module tb_switch_led_controller;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int DB_LAT = 6;
`else
  localparam int DB_LAT = 3;
`endif
  localparam int REL_K = 9 - DB_LAT;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_switch;
  logic       i_mode_btn;
  logic [3:0] o_LED;
  logic [1:0] o_mode;
  logic [3:0] o_switch_db;

  int checks = 0;
  int errors = 0;

  switch_led_controller #(
    .N               (4),
    .DEBOUNCE_CYCLES (4),
    .TICK_CYCLES     (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_switch    (i_switch),
    .i_mode_btn  (i_mode_btn),
    .o_LED       (o_LED),
    .o_mode      (o_mode),
    .o_switch_db (o_switch_db)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Raise the button; mode flips DB_LAT+1 edges later. Returns just after that edge.
  task automatic press_start(input logic [1:0] prev_m, input logic [1:0] next_m);
    i_mode_btn = 1'b1;
    cyc(DB_LAT);
    chk("mode_before_adv", {6'd0, o_mode}, {6'd0, prev_m});
    cyc(1);
    chk("mode_after_adv", {6'd0, o_mode}, {6'd0, next_m});
  endtask

  task automatic release_btn(input logic [1:0] m);
    cyc(REL_K);
    i_mode_btn = 1'b0;
    cyc(DB_LAT + 3);
    chk("mode_after_release", {6'd0, o_mode}, {6'd0, m});
  endtask

  initial begin
    logic [3:0] e_db, e_led;

    i_rst_n    = 1'b0;
    i_switch   = 4'b0000;
    i_mode_btn = 1'b0;
    cyc(2);
    chk("rst_led", {4'd0, o_LED}, 8'd0);
    chk("rst_mode", {6'd0, o_mode}, 8'd0);
    chk("rst_db", {4'd0, o_switch_db}, 8'd0);
    i_rst_n = 1'b1;
    cyc(2);
    chk("idle_led", {4'd0, o_LED}, 8'd0);
    chk("idle_mode", {6'd0, o_mode}, 8'd0);

    // PASS latency: db after DB_LAT edges, LED one edge later.
    i_switch = 4'b1010;
    for (int k = 1; k <= DB_LAT + 1; k++) begin
      cyc(1);
      e_db  = (k >= DB_LAT) ? 4'b1010 : 4'b0000;
      e_led = (k >= DB_LAT + 1) ? 4'b1010 : 4'b0000;
      chk("pass_lat_db", {4'd0, o_switch_db}, {4'd0, e_db});
      chk("pass_lat_led", {4'd0, o_LED}, {4'd0, e_led});
    end

    // Three-cycle glitch.
    i_switch = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 3) i_switch = 4'b1010;
`ifdef SWITCH_DEBOUNCE_EN
      e_db  = 4'b1010;
      e_led = 4'b1010;
`else
      e_db  = (k >= 3 && k <= 5) ? 4'b0100 : 4'b1010;
      e_led = (k >= 4 && k <= 6) ? 4'b0100 : 4'b1010;
`endif
      chk("glitch_db", {4'd0, o_switch_db}, {4'd0, e_db});
      chk("glitch_led", {4'd0, o_LED}, {4'd0, e_led});
    end

    // Mode cycling with switches 0101.
    i_switch = 4'b0101;
    cyc(DB_LAT + 2);
    chk("settle_db", {4'd0, o_switch_db}, 8'b0000_0101);
    chk("settle_led", {4'd0, o_LED}, 8'b0000_0101);
    press_start(2'd0, 2'd1);
    release_btn(2'd1);
    press_start(2'd1, 2'd2);
    release_btn(2'd2);
    press_start(2'd2, 2'd3);
    release_btn(2'd3);
    chk("invert_led", {4'd0, o_LED}, 8'b0000_1010);
    press_start(2'd3, 2'd0);
    release_btn(2'd0);
    chk("pass_again_led", {4'd0, o_LED}, 8'b0000_0101);

    // BLINK with 1001: starts dark, toggles every 8 cycles.
    i_switch = 4'b1001;
    cyc(DB_LAT + 2);
    chk("pass_1001_led", {4'd0, o_LED}, 8'b0000_1001);
    press_start(2'd0, 2'd1);
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (k == REL_K) i_mode_btn = 1'b0;
      e_led = (((k - 1) / 8) % 2 == 1) ? 4'b1001 : 4'b0000;
      chk("blink_led", {4'd0, o_LED}, {4'd0, e_led});
    end

    // Next press lands its mode change on the tick edge 32 cycles after BLINK entry.
    cyc(31 - DB_LAT - 24);
    press_start(2'd1, 2'd2);
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (k == REL_K) i_mode_btn = 1'b0;
      e_led = 4'b0001 << (((k - 1) / 8) % 4);
      chk("chase_led", {4'd0, o_LED}, {4'd0, e_led});
    end
    chk("chase_mode", {6'd0, o_mode}, 8'd2);

    // Asynchronous reset mid-cycle.
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_led", {4'd0, o_LED}, 8'd0);
    chk("async_rst_mode", {6'd0, o_mode}, 8'd0);
    chk("async_rst_db", {4'd0, o_switch_db}, 8'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cyc(1);
    chk("post_rst_mode", {6'd0, o_mode}, 8'd0);
    chk("post_rst_db", {4'd0, o_switch_db}, 8'd0);
    cyc(DB_LAT - 1);
    chk("post_rst_db_reacq", {4'd0, o_switch_db}, 8'b0000_1001);
    cyc(1);
    chk("post_rst_led", {4'd0, o_LED}, 8'b0000_1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
